// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction field layout,
// opcode/register constants used by the program memory image, and the
// fetch state encoding.
package fetch_unit_pkg;

   localparam int OPC_W = 4;
   localparam int REG_W = 2;

   localparam logic [OPC_W-1:0] OPCODE_NOP = 4'h0;
   localparam logic [OPC_W-1:0] OPCODE_ADD = 4'h1;
   localparam logic [OPC_W-1:0] OPCODE_SUB = 4'h2;
   localparam logic [OPC_W-1:0] OPCODE_AND = 4'h3;

   localparam logic [REG_W-1:0] R0 = 2'd0;
   localparam logic [REG_W-1:0] R1 = 2'd1;
   localparam logic [REG_W-1:0] R2 = 2'd2;
   localparam logic [REG_W-1:0] R3 = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_t;

   function automatic logic [OPC_W+REG_W-1:0] make_ins(input logic [OPC_W-1:0] opc,
                                                       input logic [REG_W-1:0] rsel);
      return {opc, rsel};
   endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: jump load, increment, and either wrap or hold at the
// last address depending on WRAP.
module fetch_unit_pc_reg #(
   parameter int ADDR_W = 5,
   parameter int WRAP   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc,
   output logic              at_last
);

   localparam logic HOLD_AT_END = (WRAP == 0);

   assign at_last = (pc == {ADDR_W{1'b1}});

   // PC update: redirect wins over increment; without wrap the last address is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (jump) begin
         pc <= jump_addr;
      end else if (inc && !(at_last && HOLD_AT_END)) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the program-memory address from the PC,
// captures the returned word into the instruction register and hands it to
// the decoder over valid/ready. Handles jump, halt/resume and end of program.
//
//   state | meaning
//   RUN   | fetching one word per cycle whenever the IR can be loaded
//   HALT  | fetch stopped by halt_req; IR drains, resume returns to RUN
//   DONE  | last address fetched (no wrap); only jump or reset leave it
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int INS_W  = 6,
   parameter int WRAP   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] addr,
   input  logic [INS_W-1:0]  ins_in,
   output logic [INS_W-1:0]  ir_out,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              halt_req,
   input  logic              resume,
   output logic              halted
);

   localparam logic [INS_W-1:0] IR_RESET = INS_W'({OPCODE_NOP, {REG_W{1'b0}}});
   localparam logic             STOP_AT_END = (WRAP == 0);

   fetch_state_t      state;
   logic              load;
   logic              fetch;
   logic [ADDR_W-1:0] pc;
   logic              at_last;

   assign load   = !ir_valid || ir_ready;
   // A fetch only happens in RUN when nothing of higher priority claims the edge.
   assign fetch  = (state == ST_RUN) && !jump_en && !halt_req && load;
   assign addr   = pc;
   assign halted = (state != ST_RUN);

   fetch_unit_pc_reg #(
      .ADDR_W (ADDR_W),
      .WRAP   (WRAP)
   ) u_pc_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .jump      (jump_en),
      .jump_addr (jump_addr),
      .inc       (fetch),
      .pc        (pc),
      .at_last   (at_last)
   );

   // Fetch FSM and instruction register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         ir_out   <= IR_RESET;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
      end else if (jump_en) begin
         // Redirect flushes the held word even if the decoder is taking it.
         state    <= ST_RUN;
         ir_valid <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (halt_req) begin
                  state <= ST_HALT;
                  if (ir_ready) ir_valid <= 1'b0;
               end else if (load) begin
                  ir_out   <= ins_in;
                  ir_pc    <= pc;
                  ir_valid <= 1'b1;
                  if (at_last && STOP_AT_END) state <= ST_DONE;
               end
            end
            ST_HALT: begin
               if (ir_ready) ir_valid <= 1'b0;
               if (!halt_req && resume) state <= ST_RUN;
            end
            ST_DONE: begin
               if (ir_ready) ir_valid <= 1'b0;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program memory model, scoreboard of expected
// {ir_pc, ir_out} transfers, and directed scenarios for stall, jump,
// halt/resume, end of program (with and without wrap) and async reset.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [4:0] addr, addr_w;
   logic [5:0] ins, ins_w;
   logic [5:0] ir_out, ir_out_w;
   logic [4:0] ir_pc, ir_pc_w;
   logic       ir_valid, ir_valid_w;
   logic       halted, halted_w;
   logic       ir_ready;
   logic       jump_en;
   logic [4:0] jump_addr;
   logic       halt_req;
   logic       resume;

   logic [5:0] mem [32];
   logic [10:0] q [$];
   int checks = 0;
   int errors = 0;

   assign ins   = mem[addr];
   assign ins_w = mem[addr_w];

   fetch_unit #(.ADDR_W(5), .INS_W(6), .WRAP(0)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .ins_in(ins), .ir_out(ir_out),
      .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .jump_en(jump_en),
      .jump_addr(jump_addr), .halt_req(halt_req), .resume(resume), .halted(halted)
   );

   fetch_unit #(.ADDR_W(5), .INS_W(6), .WRAP(1)) dut_w (
      .clk(clk), .rst_n(rst_n), .addr(addr_w), .ins_in(ins_w), .ir_out(ir_out_w),
      .ir_pc(ir_pc_w), .ir_valid(ir_valid_w), .ir_ready(ir_ready), .jump_en(jump_en),
      .jump_addr(jump_addr), .halt_req(halt_req), .resume(resume), .halted(halted_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = make_ins(OPCODE_NOP, R0);
      mem[0] = make_ins(OPCODE_ADD, R1);
      mem[1] = make_ins(OPCODE_SUB, R1);
      mem[2] = make_ins(OPCODE_ADD, R2);
      mem[3] = make_ins(OPCODE_AND, R3);
      mem[4] = make_ins(OPCODE_ADD, R3);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int a);
      logic [4:0] p;
      p = a[4:0];
      q.push_back({p, mem[p]});
   endtask

   // Called at posedge+1; reset is released before the next edge, which fetches Mem[0].
   task automatic do_reset();
      rst_n = 1'b0;
      ready_idle();
      #2;
      rst_n = 1'b1;
      ir_ready = 1'b1;
   endtask

   task automatic ready_idle();
      ir_ready = 1'b0;
      jump_en = 1'b0;
      jump_addr = '0;
      halt_req = 1'b0;
      resume = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ir_valid"}, ir_valid, 0);
      chk({tag, "_ir_pc"}, ir_pc, 0);
      chk({tag, "_ir_out"}, ir_out, 6'({OPCODE_NOP, 2'b00}));
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_addr"}, addr, 0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      chk({tag, "_drain"}, q.size(), 0);
   endtask

   // Monitor: every accepted transfer (not flushed by a jump) must match the queue head.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && ir_valid && ir_ready && !jump_en) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: actual pc=%0d ins=%b required none", ir_pc, ir_out);
            end else begin
               e = q.pop_front();
               if ({ir_pc, ir_out} !== e) begin
                  errors++;
                  $display("FAIL sb_transfer: actual pc=%0d ins=%b required pc=%0d ins=%b",
                           ir_pc, ir_out, e[10:6], e[5:0]);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b1;
      ready_idle();
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("por");
      chk("por_addr_w", addr_w, 0);
      tick();

      // 1: straight-line fetch
      do_reset();
      for (int i = 0; i < 6; i++) push(i);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t1_valid", ir_valid, 1);
      end
      tick();
      ir_ready = 1'b0;
      drain("t1");

      // 2: backpressure holds IR and PC
      do_reset();
      push(0); push(1); push(2);
      tick(); tick();
      ir_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_ir", ir_out, mem[1]);
         chk("t2_hold_pc", ir_pc, 1);
         chk("t2_hold_addr", addr, 2);
      end
      ir_ready = 1'b1;
      tick();
      chk("t2_resume_ir", ir_out, mem[2]);
      tick();
      ir_ready = 1'b0;
      drain("t2");

      // 3: jump flushes held word, one bubble
      do_reset();
      push(3); push(4);
      tick();
      jump_en = 1'b1; jump_addr = 5'd3;
      tick();
      jump_en = 1'b0;
      chk("t3_bubble", ir_valid, 0);
      chk("t3_addr", addr, 3);
      tick();
      chk("t3_after_valid", ir_valid, 1);
      tick(); tick();
      ir_ready = 1'b0;
      drain("t3");

      // 4: halt, drain, resume
      do_reset();
      push(0); push(1); push(2);
      tick();
      ir_ready = 1'b0; halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("t4_halted", halted, 1);
      chk("t4_addr", addr, 1);
      chk("t4_pending", ir_valid, 1);
      tick();
      chk("t4_addr_frozen", addr, 1);
      chk("t4_ir_kept", ir_out, mem[0]);
      ir_ready = 1'b1;
      tick();
      chk("t4_drained", ir_valid, 0);
      chk("t4_ir_after_drain", ir_out, mem[0]);
      halt_req = 1'b1; resume = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("t4_halt_resume_both", halted, 1);
      tick();
      resume = 1'b0;
      chk("t4_resumed", halted, 0);
      chk("t4_no_fetch_yet", ir_valid, 0);
      tick(); tick(); tick();
      ir_ready = 1'b0;
      drain("t4");

      // 5: end of program, WRAP=0 vs WRAP=1
      do_reset();
      for (int i = 0; i < 32; i++) push(i);
      repeat (32) tick();
      chk("t5_last_pc", ir_pc, 31);
      chk("t5_done", halted, 1);
      chk("t5_addr", addr, 31);
      chk("t5w_pc31", ir_pc_w, 31);
      chk("t5w_running", halted_w, 0);
      tick();
      chk("t5_done_empty", ir_valid, 0);
      chk("t5_done_addr", addr, 31);
      chk("t5w_wrap_pc", ir_pc_w, 0);
      chk("t5w_wrap_ir", ir_out_w, mem[0]);
      chk("t5w_no_bubble", ir_valid_w, 1);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("t5_resume_ignored", halted, 1);
      chk("t5_resume_no_fetch", ir_valid, 0);
      push(0);
      jump_en = 1'b1; jump_addr = 5'd0;
      tick();
      jump_en = 1'b0;
      chk("t5_jump_leaves_done", halted, 0);
      chk("t5_jump_addr", addr, 0);
      tick(); tick();
      ir_ready = 1'b0;
      drain("t5");

      // 6: async reset mid-stream
      do_reset();
      push(0); push(1);
      tick(); tick(); tick();
      #3 rst_n = 1'b0;
      #1 chk_reset_vals("t6_async");
      @(posedge clk);
      #1 chk("t6_held_in_reset", ir_valid, 0);
      #2 rst_n = 1'b1;
      push(0); push(1); push(2);
      repeat (4) tick();
      ir_ready = 1'b0;
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
